pc_jump_unit: RTL and testbench

PC_JUMP_UNIT -- requirements
Module: pc_jump_unit

---
 rtl/pc_jump_pkg.sv | 41 ++++
 rtl/pc_jump_unit_jump_table.sv | 72 +++++++
 rtl/pc_jump_unit.sv | 124 ++++++++++++
 tb/tb_pc_jump_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_jump_pkg.sv
// Shared types and constants for the PC jump unit: FSM state encoding,
// jump-table entry layout and the power-on/reset table contents.
package pc_jump_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int OFF_W_DEF = 8;
    localparam int DEPTH_DEF = 32;
    localparam int LUT_IDX_W = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic                        abs;
        logic signed [OFF_W_DEF-1:0] value;
    } jump_entry_t;

    function automatic jump_entry_t mk_entry(input logic abs, input int value);
        jump_entry_t e;
        e.abs   = abs;
        e.value = OFF_W_DEF'(value);
        return e;
    endfunction

    // Entry 0 is the rightmost element; unlisted entries are relative 0.
    localparam jump_entry_t [DEPTH_DEF-1:0] LUT_INIT = {
        {(DEPTH_DEF-8){mk_entry(1'b0, 0)}},
        mk_entry(1'b1, -1),
        mk_entry(1'b1, 100),
        mk_entry(1'b0, -3),
        mk_entry(1'b0, 10),
        mk_entry(1'b0, 0),
        mk_entry(1'b0, 0),
        mk_entry(1'b1, 8),
        mk_entry(1'b0, 1)
    };

endpackage

// File: rtl/pc_jump_unit_jump_table.sv
// Jump-table storage with a combinational read port.
// PC_JUMP_LUT_WR_EN selects a writable register array; otherwise the table is the LUT_INIT ROM.
module jump_table
    import pc_jump_pkg::*;
#(
    parameter int OFF_W = OFF_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PTR_W-1:0]        ptr,
    input  logic                    wr_en,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic                    wr_abs,
    input  logic signed [OFF_W-1:0] wr_data,
    output logic                    rd_valid,
    output logic                    rd_abs,
    output logic signed [OFF_W-1:0] rd_value
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic init_abs(input int i);
        jump_entry_t e;
        e = (i < DEPTH_DEF) ? LUT_INIT[i[LUT_IDX_W-1:0]] : '0;
        return e.abs;
    endfunction

    // Sign-extends (or truncates) the package-width value to this table's width.
    function automatic logic signed [OFF_W-1:0] init_value(input int i);
        jump_entry_t e;
        e = (i < DEPTH_DEF) ? LUT_INIT[i[LUT_IDX_W-1:0]] : '0;
        return OFF_W'(e.value);
    endfunction

    logic [IDX_W-1:0] rd_idx;

    assign rd_idx   = ptr[IDX_W-1:0];
    assign rd_valid = 32'(ptr) < DEPTH;

`ifdef PC_JUMP_LUT_WR_EN
    logic                    abs_q [DEPTH];
    logic signed [OFF_W-1:0] val_q [DEPTH];
    logic [IDX_W-1:0]        wr_idx;

    assign wr_idx = wr_ptr[IDX_W-1:0];

    // Reads see the pre-write contents, so a same-cycle write lands one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                abs_q[i] <= init_abs(i);
                val_q[i] <= init_value(i);
            end
        end else if (wr_en && (32'(wr_ptr) < DEPTH)) begin
            abs_q[wr_idx] <= wr_abs;
            val_q[wr_idx] <= wr_data;
        end
    end

    assign rd_abs   = rd_valid ? abs_q[rd_idx] : 1'b0;
    assign rd_value = rd_valid ? val_q[rd_idx] : '0;
`else
    logic unused_wr;

    assign unused_wr = ^{clk, reset, wr_en, wr_ptr, wr_abs, wr_data};
    assign rd_abs    = rd_valid ? init_abs(int'(rd_idx)) : 1'b0;
    assign rd_value  = rd_valid ? init_value(int'(rd_idx)) : '0;
`endif

endmodule

// File: rtl/pc_jump_unit.sv
// Program-counter sequencer with IDLE/RUN/HALT control and table-driven jumps.
// Table writability is controlled by the PC_JUMP_LUT_WR_EN macro (see jump_table).
module pc_jump_unit
    import pc_jump_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt_req,
    input  logic                    branch,
    input  logic [PTR_W-1:0]        ptr,
    input  logic                    wr_en,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic                    wr_abs,
    input  logic signed [OFF_W-1:0] wr_data,
    output logic [PC_W-1:0]         pc,
    output logic                    running,
    output logic                    done,
    output logic                    bad_ptr
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_HALT = ST_HALT;

    logic [1:0]              state_q;
    logic [PC_W-1:0]         pc_q;
    logic                    bad_q;
    logic                    rd_valid;
    logic                    rd_abs;
    logic signed [OFF_W-1:0] rd_value;
    logic [PC_W-1:0]         pc_next;

    jump_table #(
        .OFF_W (OFF_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_jump_table (
        .clk      (clk),
        .reset    (reset),
        .ptr      (ptr),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr),
        .wr_abs   (wr_abs),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_abs   (rd_abs),
        .rd_value (rd_value)
    );

    // Absolute targets use the raw entry bits; relative ones are sign-extended, wrapping mod 2^PC_W.
    function automatic logic [PC_W-1:0] branch_target(
        input logic [PC_W-1:0]         cur,
        input logic                    is_abs,
        input logic signed [OFF_W-1:0] value
    );
        if (is_abs) begin
            return PC_W'($unsigned(value));
        end
        return cur + PC_W'(value);
    endfunction

    always_comb begin
        pc_next = pc_q + PC_W'(1);
        if (branch && rd_valid) begin
            pc_next = branch_target(pc_q, rd_abs, rd_value);
        end
    end

    // State / PC register stage: start wins over halt_req, which wins over branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pc_q    <= '0;
                        bad_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        pc_q  <= '0;
                        bad_q <= 1'b0;
                    end else if (halt_req) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q <= pc_next;
                        if (branch && !rd_valid) begin
                            bad_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pc_q    <= '0;
                        bad_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    pc_q    <= '0;
                    bad_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc      = pc_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_HALT);
    assign bad_ptr = bad_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Self-checking bench for pc_jump_unit against a behavioural reference model.
module tb_pc_jump_unit;

    localparam int PC_W   = 10;
    localparam int OFF_W  = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 5;
    localparam int PC_MOD = 1 << PC_W;

`ifdef PC_JUMP_LUT_WR_EN
    localparam bit TBL_WRITABLE = 1'b1;
`else
    localparam bit TBL_WRITABLE = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    halt_req;
    logic                    branch;
    logic [PTR_W-1:0]        ptr;
    logic                    wr_en;
    logic [PTR_W-1:0]        wr_ptr;
    logic                    wr_abs;
    logic signed [OFF_W-1:0] wr_data;
    logic [PC_W-1:0]         pc;
    logic                    running;
    logic                    done;
    logic                    bad_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_pc;
    bit m_run;
    bit m_halt;
    bit m_bad;
    bit m_abs [DEPTH];
    int m_val [DEPTH];

    always #5 clk = ~clk;

    pc_jump_unit #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .halt_req (halt_req),
        .branch   (branch),
        .ptr      (ptr),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr),
        .wr_abs   (wr_abs),
        .wr_data  (wr_data),
        .pc       (pc),
        .running  (running),
        .done     (done),
        .bad_ptr  (bad_ptr)
    );

    task automatic model_load_init();
        for (int i = 0; i < DEPTH; i++) begin
            m_abs[i] = 1'b0;
            m_val[i] = 0;
        end
        m_val[0] = 1;
        m_abs[1] = 1'b1; m_val[1] = 8;
        m_val[4] = 10;
        m_val[5] = -3;
        m_abs[6] = 1'b1; m_val[6] = 100;
        m_abs[7] = 1'b1; m_val[7] = -1;
    endtask

    task automatic model_clock();
        int p;
        int wp;
        bit e_abs;
        int e_val;
        p = int'(ptr);
        wp = int'(wr_ptr);
        e_abs = 1'b0;
        e_val = 0;
        if (p < DEPTH) begin
            e_abs = m_abs[p];
            e_val = m_val[p];
        end
        if (reset) begin
            m_run = 1'b0; m_halt = 1'b0; m_pc = 0; m_bad = 1'b0;
            model_load_init();
            return;
        end
        if (!m_run && !m_halt) begin
            if (start) begin
                m_run = 1'b1; m_pc = 0; m_bad = 1'b0;
            end
        end else if (m_halt) begin
            if (start) begin
                m_halt = 1'b0; m_run = 1'b1; m_pc = 0; m_bad = 1'b0;
            end
        end else begin
            if (start) begin
                m_pc = 0; m_bad = 1'b0;
            end else if (halt_req) begin
                m_run = 1'b0; m_halt = 1'b1;
            end else if (branch && p >= DEPTH) begin
                m_pc = (m_pc + 1) % PC_MOD; m_bad = 1'b1;
            end else if (branch && e_abs) begin
                m_pc = (e_val & 255) % PC_MOD;
            end else if (branch) begin
                m_pc = ((m_pc + e_val) % PC_MOD + PC_MOD) % PC_MOD;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
        if (TBL_WRITABLE && wr_en && wp < DEPTH) begin
            m_abs[wp] = wr_abs;
            m_val[wp] = int'(wr_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_inputs();
        start = 1'b0; halt_req = 1'b0; branch = 1'b0; ptr = '0;
        wr_en = 1'b0; wr_ptr = '0; wr_abs = 1'b0; wr_data = '0;
    endtask

    task automatic run_to(input int target);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (target) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if ({pc, running, done, bad_ptr} !== {10'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_state: pc=%0d run=%b done=%b bad=%b expected pc=0 run=0 done=0 bad=0",
                     pc, running, done, bad_ptr);
        end
        step();
        n_tests++;
        if (int'(pc) !== 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: pc=%0d run=%b expected pc=0 run=0", pc, running);
        end
    endtask

    task automatic test_count();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (int'(pc) !== 0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_pc: pc=%0d run=%b expected pc=0 run=1", pc, running);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_tests++;
            if (int'(pc) !== i || running !== 1'b1 || int'(pc) !== m_pc) begin
                n_fail++;
                $display("FAIL count_pc: pc=%0d run=%b expected pc=%0d run=1", pc, running, i);
            end
        end
    endtask

    task automatic test_branch_abs_rel();
        run_to(20);
        branch = 1'b1; ptr = 5'd1;
        wr_en = 1'b1; wr_ptr = 5'd2; wr_abs = 1'b0; wr_data = -8'sd3;
        step();
        wr_en = 1'b0;
        n_tests++;
        if (int'(pc) !== 8) begin
            n_fail++;
            $display("FAIL branch_abs: pc=%0d expected 8", pc);
        end
        ptr = 5'd2;
        step();
        n_tests++;
        if (int'(pc) !== m_pc || int'(pc) !== (TBL_WRITABLE ? 5 : 8)) begin
            n_fail++;
            $display("FAIL branch_rel_written: pc=%0d expected %0d", pc, m_pc);
        end
        ptr = 5'd5;
        step();
        n_tests++;
        if (int'(pc) !== m_pc) begin
            n_fail++;
            $display("FAIL branch_rel_neg: pc=%0d expected %0d", pc, m_pc);
        end
        ptr = 5'd7;
        step();
        branch = 1'b0;
        n_tests++;
        if (int'(pc) !== 255) begin
            n_fail++;
            $display("FAIL branch_abs_zext: pc=%0d expected 255", pc);
        end
    endtask

    task automatic test_wrap();
        run_to(1020);
        n_tests++;
        if (int'(pc) !== 1020) begin
            n_fail++;
            $display("FAIL wrap_setup: pc=%0d expected 1020", pc);
        end
        branch = 1'b1; ptr = 5'd4;
        step();
        branch = 1'b0;
        n_tests++;
        if (int'(pc) !== 6) begin
            n_fail++;
            $display("FAIL wrap_rel: pc=%0d expected 6", pc);
        end
    endtask

    task automatic test_same_cycle();
        run_to(10);
        branch = 1'b1; ptr = 5'd3;
        wr_en = 1'b1; wr_ptr = 5'd3; wr_abs = 1'b0; wr_data = 8'sd4;
        step();
        wr_en = 1'b0;
        n_tests++;
        if (int'(pc) !== 10) begin
            n_fail++;
            $display("FAIL same_cycle_old: pc=%0d expected 10", pc);
        end
        step();
        branch = 1'b0;
        n_tests++;
        if (int'(pc) !== m_pc || int'(pc) !== (TBL_WRITABLE ? 14 : 10)) begin
            n_fail++;
            $display("FAIL same_cycle_new: pc=%0d expected %0d", pc, m_pc);
        end
    endtask

    task automatic test_halt_priority();
        run_to(7);
        halt_req = 1'b1; branch = 1'b1; ptr = 5'd1;
        step();
        halt_req = 1'b0; branch = 1'b0;
        n_tests++;
        if (int'(pc) !== 7 || done !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_prio: pc=%0d done=%b run=%b expected pc=7 done=1 run=0", pc, done, running);
        end
        step();
        n_tests++;
        if (int'(pc) !== 7 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_hold: pc=%0d done=%b expected pc=7 done=1", pc, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (int'(pc) !== 0 || running !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_restart: pc=%0d run=%b done=%b expected pc=0 run=1 done=0", pc, running, done);
        end
    endtask

    task automatic test_bad_ptr();
        run_to(3);
        branch = 1'b1; ptr = 5'd31;
        step();
        branch = 1'b0;
        n_tests++;
        if (int'(pc) !== 4 || bad_ptr !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ptr_set: pc=%0d bad=%b expected pc=4 bad=1", pc, bad_ptr);
        end
        step();
        n_tests++;
        if (int'(pc) !== 5 || bad_ptr !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ptr_sticky: pc=%0d bad=%b expected pc=5 bad=1", pc, bad_ptr);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (int'(pc) !== 0 || bad_ptr !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_ptr_reset: pc=%0d bad=%b run=%b expected pc=0 bad=0 run=0", pc, bad_ptr, running);
        end
        run_to(2);
        branch = 1'b1; ptr = 5'd16;
        step();
        branch = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (bad_ptr !== 1'b0 || m_bad !== 1'b0 || int'(pc) !== 0) begin
            n_fail++;
            $display("FAIL bad_ptr_start_clear: pc=%0d bad=%b expected pc=0 bad=0", pc, bad_ptr);
        end
    endtask

    task automatic test_reset_midrun();
        run_to(5);
        reset = 1'b1; start = 1'b1;
        wr_en = 1'b1; wr_ptr = 5'd4; wr_abs = 1'b0; wr_data = 8'sd50;
        step();
        reset = 1'b0; start = 1'b0; wr_en = 1'b0;
        n_tests++;
        if (int'(pc) !== 0 || running !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun: pc=%0d run=%b done=%b expected pc=0 run=0 done=0", pc, running, done);
        end
        run_to(2);
        branch = 1'b1; ptr = 5'd4;
        step();
        branch = 1'b0;
        n_tests++;
        if (int'(pc) !== 12) begin
            n_fail++;
            $display("FAIL reset_reload: pc=%0d expected 12", pc);
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 29) == 0);
            halt_req = !start && ($urandom_range(0, 19) == 0);
            branch   = ($urandom_range(0, 2) == 0);
            ptr      = PTR_W'($urandom_range(0, 31));
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_ptr   = PTR_W'($urandom_range(0, 31));
            wr_abs   = 1'($urandom_range(0, 1));
            wr_data  = OFF_W'($urandom_range(0, 255));
            step();
            n_tests++;
            if (int'(pc) !== m_pc || running !== m_run || done !== m_halt || bad_ptr !== m_bad) begin
                n_fail++;
                $display("FAIL random_c%0d: pc=%0d run=%b done=%b bad=%b expected pc=%0d run=%b done=%b bad=%b",
                         c, pc, running, done, bad_ptr, m_pc, m_run, m_halt, m_bad);
            end
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        m_pc = 0; m_run = 1'b0; m_halt = 1'b0; m_bad = 1'b0;
        model_load_init();
        test_reset();
        test_count();
        test_branch_abs_rel();
        test_wrap();
        test_same_cycle();
        test_halt_priority();
        test_bad_ptr();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
